// File: rtl/pipe_hazard_if.sv
// Control bundle between the LC-3b pipeline datapath and its hazard/sequencing unit.
// master = datapath side (drives hazard inputs), slave = hazard controller.
interface pipe_hazard_if #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned REG_W      = 3,
  parameter int unsigned NUM_SRC    = 2
);
  // hazard inputs
  logic                       imem_resp;
  logic                       dmem_stall;
  logic                       br_taken;
  logic [NUM_SRC*REG_W-1:0]   id_src_regs;
  logic [NUM_SRC-1:0]         id_src_used;
  logic [REG_W-1:0]           ex_dest_reg;
  logic                       ex_is_load;
  // sequencing outputs
  logic                       pc_load;
  logic                       pc_sel_branch;
  logic [NUM_STAGES-2:0]      reg_load;
  logic [NUM_STAGES-2:0]      stage_valid;
  logic                       load_use_stall;

  modport master (
    output imem_resp, dmem_stall, br_taken, id_src_regs, id_src_used,
           ex_dest_reg, ex_is_load,
    input  pc_load, pc_sel_branch, reg_load, stage_valid, load_use_stall
  );

  modport slave (
    input  imem_resp, dmem_stall, br_taken, id_src_regs, id_src_used,
           ex_dest_reg, ex_is_load,
    output pc_load, pc_sel_branch, reg_load, stage_valid, load_use_stall
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing and hazard control for the LC-3b pipelined CPU.
// Per-stage load enables and valid bits replace the global pipeline freeze:
// dmem stall holds the front end while older stages drain, a taken branch
// flushes the younger stages, a load-use pair gets one ID bubble, and an
// imem miss inserts a fetch bubble. Priority: dmem stall > branch > load-use
// > imem miss > normal advance.
// Optional build macro PIPE_PERF_CNT_EN adds stall/flush/bubble counters.
// Legal configuration: 4 <= NUM_STAGES <= 8, 2 <= MEM_STAGE <= NUM_STAGES-2,
// 2 <= BR_STAGE <= MEM_STAGE.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned MEM_STAGE  = 3,
  parameter int unsigned BR_STAGE   = 3,
  parameter int unsigned REG_W      = 3,
  parameter int unsigned NUM_SRC    = 2
) (
  input  logic          clk,
  input  logic          reset,
  pipe_hazard_if.slave  hz
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_flush_cnt,
  output logic [31:0]   perf_bubble_cnt
`endif
);

  // number of pipeline registers R_1..R_(NUM_STAGES-1)
  localparam int unsigned NR    = NUM_STAGES - 1;
  localparam int unsigned CNT_W = 32;

  // R_1..R_MEM_STAGE freeze during a dmem stall; R_(MEM_STAGE+1) takes a bubble
  localparam logic [NR-1:0] MEM_HOLD_M = NR'((64'd1 << MEM_STAGE) - 64'd1);
  localparam logic [NR-1:0] MEM_BUB_M  = NR'(64'd1 << MEM_STAGE);
  // R_1..R_BR_STAGE hold instructions younger than a resolving branch
  localparam logic [NR-1:0] FLUSH_M    = NR'((64'd1 << BR_STAGE) - 64'd1);
  // load-use: R_1 holds, R_2 takes the bubble
  localparam logic [NR-1:0] R1_M       = NR'(1);
  localparam logic [NR-1:0] R12_M      = NR'(3);
  localparam logic [NR-1:0] ALL_M      = {NR{1'b1}};

  logic [NR-1:0] stage_valid_q;
  logic [NR-1:0] stage_valid_d;
  logic [NR-1:0] shifted_c;

  logic          src_hit_c;
  logic          ms_c;
  logic          bt_c;
  logic          lu_c;
  logic          im_c;

  logic          pc_load_c;
  logic          pc_sel_branch_c;
  logic          load_use_stall_c;
  logic [NR-1:0] reg_load_c;

  // Every register advanced by one: R_k takes v[k-1], R_1 gets a bubble
  assign shifted_c = {stage_valid_q[NR-2:0], 1'b0};

  // Qualified hazard events; invalid stages never raise MS, BT or LU
  always_comb begin
    src_hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (hz.id_src_used[i] && (hz.id_src_regs[i*REG_W +: REG_W] == hz.ex_dest_reg)) begin
        src_hit_c = 1'b1;
      end
    end
    ms_c = hz.dmem_stall & stage_valid_q[MEM_STAGE-1];
    bt_c = hz.br_taken   & stage_valid_q[BR_STAGE-1];
    lu_c = hz.ex_is_load & stage_valid_q[1] & stage_valid_q[0] & src_hit_c;
    im_c = ~hz.imem_resp;
  end

  // Priority case selection: load enables, PC control and next valid bits
  always_comb begin
    pc_load_c        = 1'b0;
    pc_sel_branch_c  = 1'b0;
    load_use_stall_c = 1'b0;
    reg_load_c       = '0;
    stage_valid_d    = stage_valid_q;
    if (reset) begin
      stage_valid_d = '0;
    end else if (ms_c) begin
      // front end frozen, older stages drain behind a bubble
      reg_load_c    = ~MEM_HOLD_M;
      stage_valid_d = (stage_valid_q & MEM_HOLD_M) | (shifted_c & ~MEM_HOLD_M & ~MEM_BUB_M);
    end else if (bt_c) begin
      pc_load_c       = 1'b1;
      pc_sel_branch_c = 1'b1;
      reg_load_c      = ALL_M;
      stage_valid_d   = shifted_c & ~FLUSH_M;
    end else if (lu_c) begin
      load_use_stall_c = 1'b1;
      reg_load_c       = ~R1_M;
      stage_valid_d    = (stage_valid_q & R1_M) | (shifted_c & ~R12_M);
    end else if (im_c) begin
      reg_load_c    = ALL_M;
      stage_valid_d = shifted_c;
    end else begin
      pc_load_c     = 1'b1;
      reg_load_c    = ALL_M;
      stage_valid_d = shifted_c | R1_M;
    end
  end

  // Stage valid bits; reset discards all in-flight state
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_q <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
    end
  end

  assign hz.pc_load        = pc_load_c;
  assign hz.pc_sel_branch  = pc_sel_branch_c;
  assign hz.load_use_stall = load_use_stall_c;
  assign hz.reg_load       = reg_load_c;
  assign hz.stage_valid    = stage_valid_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;

  // One counter per event class, following the same priority as the sequencer
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ms_c) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (bt_c) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (lu_c || im_c) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared and held while reset is high
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
